// File: rtl/aes128_encrypt_core.sv
// Iterative AES-128 encryption core: one round per clock with on-the-fly key expansion.
// Define AES_DUAL_ROUND_EN to compute two chained rounds per clock. Vectors are MSB-first: byte 0 is bits [127:120].
module aes128_encrypt_core #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [127:0] in,
    input  logic [127:0] key,
    output logic [127:0] out,
    output logic         busy,
    output logic         done,
    output logic         fsm_state
);
    // Handshake: start is sampled only while idle (busy=0); done pulses for one cycle
    // when out is updated, and out holds until the next completed block or reset.
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} fsm_t;

    localparam logic [3:0] LAST = 4'(NR);

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX_TBL[2047 - 8*int'(a) -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        case (r)
            4'd1:    return 8'h01;
            4'd2:    return 8'h02;
            4'd3:    return 8'h04;
            4'd4:    return 8'h08;
            4'd5:    return 8'h10;
            4'd6:    return 8'h20;
            4'd7:    return 8'h40;
            4'd8:    return 8'h80;
            4'd9:    return 8'h1b;
            4'd10:   return 8'h36;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w0, w1, w2, w3, t;
        {w0, w1, w2, w3} = k;
        t  = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])} ^ {rc, 24'h0};
        w0 = w0 ^ t;
        w1 = w1 ^ w0;
        w2 = w2 ^ w1;
        w3 = w3 ^ w2;
        return {w0, w1, w2, w3};
    endfunction

    // Column c is bytes 4c..4c+3 and row r is byte 4c+r; the last round skips MixColumns.
    function automatic logic [127:0] aes_round(input logic [127:0] st, input logic [127:0] rk,
                                               input logic last);
        logic [7:0]   sb [16];
        logic [7:0]   sr [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] mc;
        mc = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++) begin
            a0 = sr[4*c];
            a1 = sr[4*c+1];
            a2 = sr[4*c+2];
            a3 = sr[4*c+3];
            if (last) begin
                mc[127-32*c -: 32] = {a0, a1, a2, a3};
            end else begin
                mc[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                                      a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                                      a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                                      xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
            end
        end
        return mc ^ rk;
    endfunction

    fsm_t         fsm_q, fsm_next;
    logic [127:0] state_q, rkey_q;
    logic [3:0]   round_q;
    logic [127:0] rk1, res, rk_res;
    logic [3:0]   step;
    logic         last_step;
    logic         load;

    assign rk1 = next_key(rkey_q, rcon(round_q));

`ifdef AES_DUAL_ROUND_EN
    logic [127:0] st1, rk2;
    assign st1       = aes_round(state_q, rk1, 1'b0);
    assign rk2       = next_key(rk1, rcon(round_q + 4'd1));
    assign res       = aes_round(st1, rk2, (round_q + 4'd1) == LAST);
    assign rk_res    = rk2;
    assign step      = 4'd2;
    assign last_step = (round_q + 4'd1) == LAST;
`else
    assign res       = aes_round(state_q, rk1, round_q == LAST);
    assign rk_res    = rk1;
    assign step      = 4'd1;
    assign last_step = round_q == LAST;
`endif

    assign load      = (fsm_q == IDLE) && start;
    assign busy      = (fsm_q == RUN);
    assign fsm_state = fsm_q;

    always_ff @(posedge clk) begin
        if (reset) fsm_q <= IDLE;
        else       fsm_q <= fsm_next;
    end

    always_comb begin
        fsm_next = fsm_q;
        case (fsm_q)
            IDLE:    if (start) fsm_next = RUN;
            RUN:     if (last_step) fsm_next = IDLE;
            default: fsm_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= '0;
            rkey_q  <= '0;
            round_q <= '0;
            out     <= '0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                state_q <= in ^ key;
                rkey_q  <= key;
                round_q <= 4'd1;
            end else if (fsm_q == RUN) begin
                state_q <= res;
                rkey_q  <= rk_res;
                round_q <= round_q + step;
                if (last_step) begin
                    out  <= res;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_aes128_encrypt_core.sv
// Directed bench for aes128_encrypt_core using FIPS-197 known-answer vectors.
module tb_aes128_encrypt_core;
`ifdef AES_DUAL_ROUND_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 11;
`endif
    localparam logic [127:0] B_IN  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_OUT = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_IN  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_OUT = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] Z_OUT = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [127:0] in, key;
    logic [127:0] out;
    logic         busy, done, fsm_state;

    int passed = 0;
    int total  = 0;
    int edges;
    int done_seen;
    logic held;

    aes128_encrypt_core dut (
        .clk(clk), .reset(reset), .start(start), .in(in), .key(key),
        .out(out), .busy(busy), .done(done), .fsm_state(fsm_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Pulse start for the load edge; returns #1 after that edge.
    task automatic load_block(input logic [127:0] pin, input logic [127:0] pkey);
        in = pin;
        key = pkey;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges after the load edge until done; optionally pulses a zero start at edge inj.
    task automatic wait_done(input int inj, output int n, output logic held_ok);
        logic [127:0] o0;
        n = 0;
        held_ok = 1'b1;
        o0 = out;
        while (n < 30 && done !== 1'b1) begin
            @(posedge clk);
            #1;
            n++;
            if (done !== 1'b1 && out !== o0) held_ok = 1'b0;
            if (n == inj) begin
                start = 1'b1;
                in = '0;
                key = '0;
            end else begin
                start = 1'b0;
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        in = B_IN;
        key = B_KEY;
        repeat (2) @(posedge clk);
        #1;
        check("reset_out", out, '0);
        check("reset_busy", 128'(busy), 128'(0));
        check("reset_done", 128'(done), 128'(0));
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("no_start_after_reset", 128'(busy), 128'(0));

        // App. B with an ignored start and changed inputs mid-operation
        load_block(B_IN, B_KEY);
        check("b_busy_after_load", 128'(busy), 128'(1));
        check("b_out_held_on_load", out, '0);
        wait_done(3, edges, held);
        check("b_latency", 128'(edges), 128'(LAT - 1));
        check("b_done", 128'(done), 128'(1));
        check("b_out", out, B_OUT);
        check("b_out_held_during", 128'(held), 128'(1));

        // App. C.1 started on the done cycle of the previous block
        load_block(C_IN, C_KEY);
        check("c_done_pulse", 128'(done), 128'(0));
        check("c_busy", 128'(busy), 128'(1));
        check("c_prev_out_held", out, B_OUT);
        wait_done(0, edges, held);
        check("c_latency", 128'(edges), 128'(LAT - 1));
        check("c_out", out, C_OUT);
        check("c_prev_held_during", 128'(held), 128'(1));
        @(posedge clk);
        #1;
        check("c_done_one_cycle", 128'(done), 128'(0));
        check("c_idle", 128'(busy), 128'(0));
        check("c_out_hold", out, C_OUT);

        // Reset five cycles after start aborts the block
        load_block(B_IN, B_KEY);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_out", out, '0);
        check("abort_done", 128'(done), 128'(0));
        done_seen = 0;
        repeat (15) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) done_seen++;
        end
        check("abort_no_done", 128'(done_seen), 128'(0));

        load_block(B_IN, B_KEY);
        wait_done(0, edges, held);
        check("b2_latency", 128'(edges), 128'(LAT - 1));
        check("b2_out", out, B_OUT);

        load_block('0, '0);
        wait_done(0, edges, held);
        check("zero_latency", 128'(edges), 128'(LAT - 1));
        check("zero_out", out, Z_OUT);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
